exe_mem_reg: RTL and testbench

EXE_MEM_REG -- requirements
Module: exe_mem_reg

---
 rtl/exe_mem_reg.sv | 133 +++++++++++++
 tb/tb_exe_mem_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_reg.sv
// exe_mem_reg: EXE->MEM pipeline register, data-RAM request and load-data hold.
// Optional forwarding outputs are enabled by defining EXE_MEM_FWD_EN.
module exe_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        exe_valid,
  output logic        exe_allowin,
  input  logic [4:0]  exe_rd,
  input  logic        exe_rf_we,
  input  logic        exe_res_from_dram,
  input  logic        exe_dram_we,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_dram_wdata,
  input  logic [31:0] exe_pc,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  output logic        mem_valid,
  output logic [4:0]  mem_rd,
  output logic        mem_rf_we,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_final_result
`ifdef EXE_MEM_FWD_EN
  ,
  output logic        mem_fwd_valid,
  output logic [4:0]  mem_fwd_rd,
  output logic [31:0] mem_fwd_data
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FRESH = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_valid;
  logic [4:0]  r_rd;
  logic        r_rf_we;
  logic        r_res_from_dram;
  logic [31:0] r_pc;
  logic [31:0] r_alu_result;
  logic [31:0] r_hold;

  logic        w_allowin;
  logic        w_accept;
  logic        w_mem_req;
  logic [31:0] w_final;

  assign w_allowin = flush | ~r_valid | wb_allowin;
  assign w_accept  = w_allowin & exe_valid & ~flush;
  assign w_mem_req = exe_res_from_dram | exe_dram_we;

  assign exe_allowin     = w_allowin;
  assign data_sram_en    = w_accept & w_mem_req;
  assign data_sram_we    = {4{exe_dram_we & data_sram_en}};
  assign data_sram_addr  = exe_alu_result;
  assign data_sram_wdata = exe_dram_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid         <= 1'b0;
      r_rd            <= 5'd0;
      r_rf_we         <= 1'b0;
      r_res_from_dram <= 1'b0;
      r_pc            <= 32'd0;
      r_alu_result    <= 32'd0;
    end else if (w_allowin) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_rd            <= exe_rd;
        r_rf_we         <= exe_rf_we;
        r_res_from_dram <= exe_res_from_dram;
        r_pc            <= exe_pc;
        r_alu_result    <= exe_alu_result;
      end
    end
  end

  // RAM data is only live the cycle after the request; latch it if WB stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_hold  <= 32'd0;
    end else if (w_accept) begin
      r_state <= S_FRESH;
    end else begin
      case (r_state)
        S_FRESH: begin
          if (flush) begin
            r_state <= S_EMPTY;
          end else if (!wb_allowin) begin
            r_state <= S_HELD;
            r_hold  <= data_sram_rdata;
          end else begin
            r_state <= S_EMPTY;
          end
        end
        S_HELD: begin
          if (flush || wb_allowin)
            r_state <= S_EMPTY;
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_final = r_alu_result;
    if (r_res_from_dram && r_state == S_FRESH)
      w_final = data_sram_rdata;
    else if (r_res_from_dram && r_state == S_HELD)
      w_final = r_hold;
  end

  assign mem_valid        = r_valid;
  assign mem_rd           = r_rd;
  assign mem_rf_we        = r_rf_we & r_valid;
  assign mem_pc           = r_pc;
  assign mem_final_result = w_final;

`ifdef EXE_MEM_FWD_EN
  assign mem_fwd_valid = r_valid & r_rf_we & (r_rd != 5'd0);
  assign mem_fwd_rd    = r_rd;
  assign mem_fwd_data  = w_final;
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// tb_exe_mem_reg: randomized and directed checks of exe_mem_reg
// against an occupant-record reference model.
module tb_exe_mem_reg;

  logic        clk = 1'b0;
  logic        rst, flush, exe_valid, exe_allowin;
  logic [4:0]  exe_rd;
  logic        exe_rf_we, exe_res_from_dram, exe_dram_we;
  logic [31:0] exe_alu_result, exe_dram_wdata, exe_pc;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        wb_allowin, mem_valid, mem_rf_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_pc, mem_final_result;
`ifdef EXE_MEM_FWD_EN
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
`endif

  exe_mem_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .exe_valid(exe_valid), .exe_allowin(exe_allowin),
    .exe_rd(exe_rd), .exe_rf_we(exe_rf_we),
    .exe_res_from_dram(exe_res_from_dram), .exe_dram_we(exe_dram_we),
    .exe_alu_result(exe_alu_result), .exe_dram_wdata(exe_dram_wdata),
    .exe_pc(exe_pc),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_pc(mem_pc),
    .mem_final_result(mem_final_result)
`ifdef EXE_MEM_FWD_EN
    ,
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;

  // Reference occupant of the stage.
  logic        o_valid;
  logic [4:0]  o_rd;
  logic        o_rf_we, o_ld;
  logic [31:0] o_pc, o_alu, o_data;
  // Load data the RAM returns on the cycle after a read request.
  logic        pend_rd;
  logic [31:0] pend_val;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    o_valid = 1'b0; o_rd = '0; o_rf_we = 1'b0; o_ld = 1'b0;
    o_pc = '0; o_alu = '0; o_data = '0;
  endtask

  // One cycle: drive, check combinational and registered outputs, advance.
  task automatic step(input logic rs, input logic fl, input logic v,
                      input logic wb, input int kind,
                      input logic [4:0] rd, input logic rfwe,
                      input logic [31:0] alu, input logic [31:0] wd,
                      input logic [31:0] pc, input logic [31:0] ldv,
                      input logic [31:0] garb);
    logic allow, acc, en;
    logic [31:0] res;
    rst = rs; flush = fl; exe_valid = v; wb_allowin = wb;
    exe_rd = rd; exe_rf_we = rfwe;
    exe_res_from_dram = (kind == K_LD);
    exe_dram_we = (kind == K_ST);
    exe_alu_result = alu; exe_dram_wdata = wd; exe_pc = pc;
    data_sram_rdata = pend_rd ? pend_val : garb;
    #1;
    allow = fl | ~o_valid | wb;
    acc = allow & v & ~fl;
    en = acc & (kind != K_ALU);
    res = (o_valid && o_ld) ? o_data : o_alu;
    check("exe_allowin", {31'd0, exe_allowin}, {31'd0, allow});
    check("sram_en", {31'd0, data_sram_en}, {31'd0, en});
    check("sram_we", {28'd0, data_sram_we},
          (en && kind == K_ST) ? 32'hF : 32'h0);
    if (en) begin
      check("sram_addr", data_sram_addr, alu);
      check("sram_wdata", data_sram_wdata, wd);
    end
    check("mem_valid", {31'd0, mem_valid}, {31'd0, o_valid});
    check("mem_rd", {27'd0, mem_rd}, {27'd0, o_rd});
    check("mem_rf_we", {31'd0, mem_rf_we}, {31'd0, o_valid & o_rf_we});
    check("mem_pc", mem_pc, o_pc);
    check("final_result", mem_final_result, res);
`ifdef EXE_MEM_FWD_EN
    check("fwd_valid", {31'd0, mem_fwd_valid},
          {31'd0, o_valid & o_rf_we & (o_rd != 0)});
    check("fwd_data", mem_fwd_data, res);
`endif
    pend_rd = en && (kind == K_LD);
    pend_val = ldv;
    if (rs) begin
      model_clear();
    end else if (allow) begin
      if (acc) begin
        o_valid = 1'b1; o_rd = rd; o_rf_we = rfwe;
        o_ld = (kind == K_LD); o_pc = pc; o_alu = alu; o_data = ldv;
      end else begin
        o_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic wb);
    step(0, 0, 0, wb, K_ALU, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 0; exe_valid = 0; wb_allowin = 1;
    exe_rd = 0; exe_rf_we = 0; exe_res_from_dram = 0; exe_dram_we = 0;
    exe_alu_result = 0; exe_dram_wdata = 0; exe_pc = 0;
    data_sram_rdata = 0;
    pend_rd = 0; pend_val = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset state.
    check("rst_allowin", {31'd0, exe_allowin}, 32'd1);
    check("rst_en", {31'd0, data_sram_en}, 32'd0);
    check("rst_result", mem_final_result, 32'd0);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);

    // Load, no stall.
    step(0, 0, 1, 1, K_LD, 5'd4, 1, 32'h100, 0, 32'h1C000010,
         32'hDEADBEEF, 0);
    idle(1);
    // Same load, WB stalls three cycles with RAM bus changed to zero.
    step(0, 0, 1, 1, K_LD, 5'd4, 1, 32'h100, 0, 32'h1C000010,
         32'hDEADBEEF, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, K_ALU, 5'd7, 1, 32'h55, 0, 32'h1C000014, 0, 0);
    check("held_result", mem_final_result, 32'hDEADBEEF);
    step(0, 0, 1, 1, K_ALU, 5'd7, 1, 32'h55, 0, 32'h1C000014, 0, 0);
    idle(1);
    // Store.
    step(0, 0, 1, 1, K_ST, 5'd0, 0, 32'h200, 32'h12345678,
         32'h1C000018, 0, 0);
    idle(1);
    // Back-to-back ALU results.
    for (int i = 1; i <= 3; i++)
      step(0, 0, 1, 1, K_ALU, 5'(i), 1, 32'(i), 0, 32'h1C000020 + 32'(4*i),
           0, 32'hFFFF0000);
    check("b2b_last", mem_final_result, 32'h3);
    idle(1);
    // Flush with a load presented.
    step(0, 1, 1, 1, K_LD, 5'd9, 1, 32'h300, 0, 32'h1C000040,
         32'hCAFEF00D, 0);
    idle(1);
    // Reset during a HELD stall.
    step(0, 0, 1, 1, K_LD, 5'd3, 1, 32'h400, 0, 32'h1C000050,
         32'hA5A5A5A5, 0);
    step(0, 0, 0, 0, K_ALU, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, K_ALU, 0, 0, 0, 0, 0, 0, 32'h77);
    check("rst_mid_result", mem_final_result, 32'd0);
    check("rst_mid_allowin", {31'd0, exe_allowin}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
           ($urandom % 3) != 0, int'($urandom % 3),
           5'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
           $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
